// File: rtl/cache_types_pkg.sv
// ----------------------------------------------------------------------------
// cache_types
// Shared types and constants for the cache subsystem.
//   - req_t            : kind of line request issued on the cache's dfp
//   - adapter_state_t  : states of the dfp-to-burst-memory adapter
//   - LINE_W / BEAT_W / BURST_LEN / OFFSET_BITS : line and burst geometry
//   - line_align()     : clears the byte-within-line offset of an address
// ----------------------------------------------------------------------------
package cache_types;

   localparam int LINE_W      = 256;
   localparam int BEAT_W      = 64;
   localparam int BURST_LEN   = LINE_W / BEAT_W;
   localparam int OFFSET_BITS = 5;

   typedef enum logic [0:0] {
      REQ_READ  = 1'b0,
      REQ_WRITE = 1'b1
   } req_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_BEAT = 3'd2,
      WR_BEAT = 3'd3,
      RESP    = 3'd4
   } adapter_state_t;

   // Line-aligned address: the offset bits inside a 32-byte line are dropped.
   function automatic logic [31:0] line_align(input logic [31:0] addr);
      return {addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
   endfunction

endpackage

// File: rtl/cacheline_adapter.sv
// ----------------------------------------------------------------------------
// cacheline_adapter
// Answers whole-line reads and writebacks from the cache's downstream-facing
// port (dfp) by running a BURST_LEN-beat burst on the burst-memory interface.
// Every output is registered.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   dfp_addr            line address (offset bits ignored)
//   dfp_read/dfp_write  line request, held by the cache until dfp_resp
//   dfp_wdata           writeback line
//   dfp_rdata           filled line, holds until the next read completes
//   dfp_resp            one-cycle completion pulse
//   bmem_addr           aligned burst address, stable for the whole burst
//   bmem_read           burst read command, held until bmem_ready
//   bmem_write          write beat valid
//   bmem_wdata          write beat data, low beat first
//   bmem_ready          memory accepts the read command / first write beat
//   bmem_raddr          address tag of a returning read beat
//   bmem_rdata          read beat data
//   bmem_rvalid         read beat valid
// ----------------------------------------------------------------------------
module cacheline_adapter
   import cache_types::*;
#(
   parameter int LINE_W    = cache_types::LINE_W,
   parameter int BEAT_W    = cache_types::BEAT_W,
   parameter int BURST_LEN = LINE_W / BEAT_W
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic [31:0]       dfp_addr,
   input  logic              dfp_read,
   input  logic              dfp_write,
   input  logic [LINE_W-1:0] dfp_wdata,
   output logic [LINE_W-1:0] dfp_rdata,
   output logic              dfp_resp,

   output logic [31:0]       bmem_addr,
   output logic              bmem_read,
   output logic              bmem_write,
   output logic [BEAT_W-1:0] bmem_wdata,
   input  logic              bmem_ready,
   input  logic [31:0]       bmem_raddr,
   input  logic [BEAT_W-1:0] bmem_rdata,
   input  logic              bmem_rvalid
);

   localparam int                    BEAT_CNT_W = $clog2(BURST_LEN);
   localparam logic [BEAT_CNT_W-1:0] LAST_BEAT  = BEAT_CNT_W'(BURST_LEN - 1);

   adapter_state_t          state_q,      state_d;
   req_t                    req_kind_q,   req_kind_d;
   logic [BEAT_CNT_W-1:0]   beat_cnt_q,   beat_cnt_d;
   logic [LINE_W-1:0]       line_q,       line_d;
   logic [LINE_W-1:0]       dfp_rdata_q,  dfp_rdata_d;
   logic                    dfp_resp_q,   dfp_resp_d;
   logic [31:0]             bmem_addr_q,  bmem_addr_d;
   logic                    bmem_read_q,  bmem_read_d;
   logic                    bmem_write_q, bmem_write_d;
   logic [BEAT_W-1:0]       bmem_wdata_q, bmem_wdata_d;

   // Line buffer viewed as beats, beat 0 in the low bits.
   logic [BEAT_W-1:0]       line_beat [BURST_LEN];

   genvar gi;
   generate
      for (gi = 0; gi < BURST_LEN; gi++) begin : g_beat_view
         assign line_beat[gi] = line_q[gi*BEAT_W +: BEAT_W];
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Next-state and output logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      req_kind_d   = req_kind_q;
      beat_cnt_d   = beat_cnt_q;
      line_d       = line_q;
      dfp_rdata_d  = dfp_rdata_q;
      dfp_resp_d   = 1'b0;
      bmem_addr_d  = bmem_addr_q;
      bmem_read_d  = bmem_read_q;
      bmem_write_d = bmem_write_q;
      bmem_wdata_d = bmem_wdata_q;

      unique case (state_q)
         IDLE: begin
            // A writeback wins over a simultaneous read; the cache keeps the
            // read asserted, so it is picked up after this write completes.
            if (dfp_write) begin
               req_kind_d   = REQ_WRITE;
               bmem_addr_d  = line_align(dfp_addr);
               line_d       = dfp_wdata;
               beat_cnt_d   = '0;
               bmem_write_d = 1'b1;
               bmem_wdata_d = dfp_wdata[BEAT_W-1:0];
               state_d      = WR_BEAT;
            end else if (dfp_read) begin
               req_kind_d   = REQ_READ;
               bmem_addr_d  = line_align(dfp_addr);
               bmem_read_d  = 1'b1;
               state_d      = RD_REQ;
            end
         end

         RD_REQ: begin
            if (bmem_read_q && bmem_ready) begin
               bmem_read_d = 1'b0;
               beat_cnt_d  = '0;
               state_d     = RD_BEAT;
            end
         end

         RD_BEAT: begin
            if (bmem_rvalid) begin
               line_d[int'(beat_cnt_q)*BEAT_W +: BEAT_W] = bmem_rdata;
               if (beat_cnt_q == LAST_BEAT) begin
                  // line_d already holds the final beat here.
                  dfp_rdata_d = line_d;
                  dfp_resp_d  = 1'b1;
                  beat_cnt_d  = '0;
                  state_d     = RESP;
               end else begin
                  beat_cnt_d  = beat_cnt_q + 1'b1;
               end
            end
         end

         WR_BEAT: begin
            // Only the first beat waits for bmem_ready; memory takes the
            // remaining beats back-to-back once the first one is accepted.
            if ((beat_cnt_q != '0) || bmem_ready) begin
               if (beat_cnt_q == LAST_BEAT) begin
                  bmem_write_d = 1'b0;
                  bmem_wdata_d = '0;
                  dfp_resp_d   = 1'b1;
                  beat_cnt_d   = '0;
                  state_d      = RESP;
               end else begin
                  beat_cnt_d   = beat_cnt_q + 1'b1;
                  bmem_wdata_d = line_beat[beat_cnt_q + 1'b1];
               end
            end
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State and output registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         req_kind_q   <= REQ_READ;
         beat_cnt_q   <= '0;
         line_q       <= '0;
         dfp_rdata_q  <= '0;
         dfp_resp_q   <= 1'b0;
         bmem_addr_q  <= '0;
         bmem_read_q  <= 1'b0;
         bmem_write_q <= 1'b0;
         bmem_wdata_q <= '0;
      end else begin
         state_q      <= state_d;
         req_kind_q   <= req_kind_d;
         beat_cnt_q   <= beat_cnt_d;
         line_q       <= line_d;
         dfp_rdata_q  <= dfp_rdata_d;
         dfp_resp_q   <= dfp_resp_d;
         bmem_addr_q  <= bmem_addr_d;
         bmem_read_q  <= bmem_read_d;
         bmem_write_q <= bmem_write_d;
         bmem_wdata_q <= bmem_wdata_d;
      end
   end

   assign dfp_rdata  = dfp_rdata_q;
   assign dfp_resp   = dfp_resp_q;
   assign bmem_addr  = bmem_addr_q;
   assign bmem_read  = bmem_read_q;
   assign bmem_write = bmem_write_q;
   assign bmem_wdata = bmem_wdata_q;

   // -------------------------------------------------------------------------
   // Protocol checks
   // -------------------------------------------------------------------------
   a_both_req: assert property (@(posedge clk) disable iff (!rst_n)
      !(state_q == IDLE && dfp_read && dfp_write))
      else $warning("cacheline_adapter: read and write requested together, serving the write");

   a_stray_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
      !(bmem_rvalid && state_q != RD_BEAT))
      else $warning("cacheline_adapter: read beat outside a read burst ignored");

   a_raddr_match: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == RD_BEAT && bmem_rvalid) |-> (bmem_raddr == bmem_addr_q))
      else $error("cacheline_adapter: returning beat tag %h differs from burst address %h",
                  bmem_raddr, bmem_addr_q);

   a_kind_read: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == RD_REQ || state_q == RD_BEAT) |-> (req_kind_q == REQ_READ))
      else $error("cacheline_adapter: read states entered for a writeback");

   a_kind_write: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == WR_BEAT) |-> (req_kind_q == REQ_WRITE))
      else $error("cacheline_adapter: write state entered for a read");

endmodule
